cpu_run_monitor: RTL
====================

# cpu_run_monitor

Synthesizable run-control and signature monitor that sits beside the `cpu` top and observes the core's PC, register write-back port and data-memory write port. Once armed, it detects program completion (PC parked at a programmable finish address), enforces a programmable cycle timeout, and folds every architectural write into a 32-bit signature. At completion it compares the signature against an expected value and reports pass/fail. It is the hardware successor to bench-side polling: parametrised in widths and hold length, usable in FPGA bring-up, and adds write-stream signature checking with an explicit timeout state.

## Interface
- `XLEN`, 32, data/address width of observed buses
- `CNT_W`, 16, width of cycle counter and timeout limit
- `HOLD`, 2, consecutive cycles PC must equal finish PC to declare completion (≥1)
- `SIG_SEED`, 32'h0, signature value loaded on arm
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_resetn`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  arm/re-arm pulse
- `i_timeout`  in  CNT_W  max RUN cycles; 0 = no timeout
- `i_finish_pc`  in  XLEN  completion PC
- `i_exp_sig`  in  32  expected signature
- `i_pc`  in  XLEN  core fetch PC
- `i_wb_en`  in  1  register write-back valid
- `i_wb_rd`  in  5  write-back destination
- `i_wb_data`  in  XLEN  write-back data
- `i_mem_we`  in  1  data-memory write valid
- `i_mem_addr`  in  XLEN  data-memory byte address
- `i_mem_wdata`  in  XLEN  data-memory write data
- `o_busy`  out  1  state == RUN
- `o_done`  out  1  state == DONE
- `o_timeout`  out  1  state == TIMEOUT
- `o_pass`  out  1  valid in DONE: signature matched
- `o_signature`  out  32  current signature
- `o_cycles`  out  CNT_W  cycles spent in RUN (saturating)

## Operation
- FSM states: IDLE, RUN, DONE, TIMEOUT.
- IDLE → RUN on `i_start`; on that edge sig ← `SIG_SEED`, cycles ← 0, hold ← 0, pass ← 0.
- `i_start` in RUN, DONE or TIMEOUT: same re-arm action, next state RUN.
- In RUN, each cycle: cycles ← cycles+1 (saturate at all-ones); signature updated from the current cycle's events.
- Signature step `f(s,d,k)` = rotl1(s) ^ d ^ k (32-bit, XLEN truncated/zero-extended to 32).
- Register event (`i_wb_en` && rd ≠ 0): s1 = f(sig, wb_data, {27'b0, rd}); otherwise s1 = sig. Writes to x0 are ignored.
- Memory event (`i_mem_we`): s2 = f(s1, mem_wdata, mem_addr); otherwise s2 = s1. Both events in one cycle: register first, then memory. sig ← s2.
- Hold counter: increments while `i_pc == i_finish_pc`, clears to 0 on mismatch. Finish condition = match this cycle && hold == HOLD-1.
- Finish → DONE; pass ← (s2 == `i_exp_sig`), including the finish cycle's events.
- Timeout condition = `i_timeout` ≠ 0 && cycles == `i_timeout`-1 → TIMEOUT; pass ← 0.
- Finish and timeout in the same cycle: finish wins.
- `i_start` has priority over finish and timeout.
- DONE/TIMEOUT are sticky: signature, cycles and pass are frozen, and events are ignored until re-armed.

## Timing
- Every output is registered; reset values are state IDLE, all flags 0, `o_signature` = `SIG_SEED`, `o_cycles` = 0.
- Asynchronous reset mid-RUN returns to IDLE immediately. No partial signature survives.
- RUN is visible the cycle after the `i_start` edge.
- DONE is visible one edge after the cycle that satisfies the finish condition.
- TIMEOUT is visible exactly `i_timeout` cycles after RUN entry; `o_cycles` = `i_timeout` at that point.
- `i_timeout`, `i_finish_pc` and `i_exp_sig` are sampled live and must be held stable while in RUN.

## Structure
- Package `cpu_mon_pkg` holds:
  - the `mon_state_e` enum (IDLE, RUN, DONE, TIMEOUT);
  - function `sig_step(s, d, k)`;
  - localparam `SIG_W` = 32.
- Sub-module `mon_sig_accum` implements the two-stage combinational fold plus the signature register, with enable and load-seed inputs.
- The top module holds the FSM, cycle counter and hold counter.

## Test plan
- Sequence: arm, wb rd=1 data 9, then mem write addr 0 data 12, then PC = finish for 2 cycles, with `i_exp_sig`=0x1C → DONE, `o_pass`=1, `o_signature`=0x0000001C.
- Same stimulus with `i_exp_sig`=0x1D → DONE, `o_pass`=0.
- wb rd=1 data 9 and mem addr 0 data 12 in the same cycle → `o_signature`=0x1C, proving register-then-memory ordering. A further wb rd=0 data 5 leaves the signature unchanged.
- `i_timeout`=10 with PC never matching → TIMEOUT visible 10 cycles after RUN entry, `o_cycles`=10, `o_pass`=0.
- PC matches finish for 1 cycle, leaves, then matches 2 cycles with HOLD=2 → DONE only after the second run. A match on cycle 9 with `i_timeout`=10 → DONE, not TIMEOUT.
- `i_resetn` low mid-RUN → IDLE immediately with all outputs at reset values. Re-arm after DONE → RUN with signature = `SIG_SEED` and cycles = 0.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// rtl/cpu_mon_pkg.sv - shared types and signature fold for the run monitor
//
// Contents:
//   SIG_W        signature width (32)
//   mon_state_e  monitor FSM states
//   sig_step     one signature fold: rotl1(s) ^ d ^ k
package cpu_mon_pkg;

  localparam int SIG_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s,
                                                input logic [SIG_W-1:0] d,
                                                input logic [SIG_W-1:0] k);
    return {s[SIG_W-2:0], s[SIG_W-1]} ^ d ^ k;
  endfunction

endpackage

// File: rtl/mon_sig_accum.sv
// rtl/mon_sig_accum.sv - signature register with two-stage write-event fold
//
// Ports:
//   i_clk, i_resetn       clock, asynchronous active-low reset
//   i_load                reload SIG_SEED (wins over i_en)
//   i_en                  commit this cycle's folded value
//   i_wb_en/rd/data       register write-back event (x0 ignored)
//   i_mem_we/addr/wdata   data-memory write event
//   o_sig_next            folded value for this cycle (combinational)
//   o_sig                 registered signature
module mon_sig_accum
  import cpu_mon_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [SIG_W-1:0]  SIG_SEED = '0
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_wb_en,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_mem_we,
  input  logic [XLEN-1:0]  i_mem_addr,
  input  logic [XLEN-1:0]  i_mem_wdata,
  output logic [SIG_W-1:0] o_sig_next,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] s1;
  logic [SIG_W-1:0] s2;

  // Register event folds first, memory event folds on top of it.
  always_comb begin
    s1 = sig_q;
    if (i_wb_en && (i_wb_rd != 5'd0)) begin
      s1 = sig_step(sig_q, SIG_W'(i_wb_data), SIG_W'(i_wb_rd));
    end
    s2 = s1;
    if (i_mem_we) begin
      s2 = sig_step(s1, SIG_W'(i_mem_wdata), SIG_W'(i_mem_addr));
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      sig_q <= SIG_SEED;
    end else if (i_load) begin
      sig_q <= SIG_SEED;
    end else if (i_en) begin
      sig_q <= s2;
    end
  end

  assign o_sig_next = s2;
  assign o_sig      = sig_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run-control, timeout and write-signature monitor
//
// Ports:
//   i_clk, i_resetn             clock, asynchronous active-low reset
//   i_start                     arm / re-arm pulse
//   i_timeout                   max RUN cycles, 0 disables
//   i_finish_pc, i_exp_sig      completion PC, expected signature
//   i_pc                        observed fetch PC
//   i_wb_en/rd/data             observed register write-back
//   i_mem_we/addr/wdata         observed data-memory write
//   o_busy/o_done/o_timeout     state flags
//   o_pass                      signature matched (meaningful in DONE)
//   o_signature, o_cycles       running signature, saturating RUN cycle count
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               CNT_W    = 16,
  parameter int               HOLD     = 2,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_timeout,
  input  logic [XLEN-1:0]  i_finish_pc,
  input  logic [SIG_W-1:0] i_exp_sig,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_wb_en,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_mem_we,
  input  logic [XLEN-1:0]  i_mem_addr,
  input  logic [XLEN-1:0]  i_mem_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_signature,
  output logic [CNT_W-1:0] o_cycles
);

  // Hold counter never exceeds HOLD, so this width always fits.
  localparam int            HW        = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pass_q, pass_d;
  logic             sig_load, sig_en;
  logic [SIG_W-1:0] sig_next;
  logic             pc_match, finish, tmo;

  mon_sig_accum #(
    .XLEN     (XLEN),
    .SIG_SEED (SIG_SEED)
  ) u_sig (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_load      (sig_load),
    .i_en        (sig_en),
    .i_wb_en     (i_wb_en),
    .i_wb_rd     (i_wb_rd),
    .i_wb_data   (i_wb_data),
    .i_mem_we    (i_mem_we),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .o_sig_next  (sig_next),
    .o_sig       (o_signature)
  );

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    hold_d   = hold_q;
    pass_d   = pass_q;
    sig_load = 1'b0;
    sig_en   = 1'b0;

    pc_match = (i_pc == i_finish_pc);
    finish   = pc_match && (hold_q == HOLD_LAST);
    // Compared against the pre-increment count so TIMEOUT lands with cycles == i_timeout.
    tmo      = (i_timeout != '0) && (cycles_q == (i_timeout - CNT_W'(1)));

    if (i_start) begin
      state_d  = RUN;
      cycles_d = '0;
      hold_d   = '0;
      pass_d   = 1'b0;
      sig_load = 1'b1;
    end else if (state_q == RUN) begin
      sig_en = 1'b1;
      if (cycles_q != '1) begin
        cycles_d = cycles_q + CNT_W'(1);
      end
      hold_d = pc_match ? hold_q + HW'(1) : '0;
      if (finish) begin
        state_d = DONE;
        pass_d  = (sig_next == i_exp_sig);
      end else if (tmo) begin
        state_d = TIMEOUT;
        pass_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      hold_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      hold_q   <= hold_d;
      pass_q   <= pass_d;
    end
  end

  assign o_busy    = (state_q == RUN);
  assign o_done    = (state_q == DONE);
  assign o_timeout = (state_q == TIMEOUT);
  assign o_pass    = pass_q;
  assign o_cycles  = cycles_q;

endmodule
